// File: rtl/div_iter_if.sv
// div_iter_if: EX-side handshake and operand bundle for the iterative divider
interface div_iter_if #(parameter int WIDTH = 32);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: multi-cycle restoring radix-2 divider for DIV/DIVU with start/ready handshake
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave d
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rneg_q, rneg_d, qneg_q, qneg_d, ready_q, ready_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d, quo_q, quo_d;
    logic [WIDTH:0]     rem_q, rem_d, rem_sh;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0]   mag1, mag2, rem_fix, quo_fix;
    logic               neg1, neg2, ge;

    assign d.result_o = result_q;
    assign d.ready_o  = ready_q;
    assign d.busy_o   = (state_q == ON) || (state_q == BYZERO);

    // next state: operand capture, one shift-subtract step per cycle, sign fix-up, handshake
    always_comb begin
        neg1     = d.signed_div_i & d.opdata1_i[WIDTH-1];
        neg2     = d.signed_div_i & d.opdata2_i[WIDTH-1];
        mag1     = neg1 ? -d.opdata1_i : d.opdata1_i;
        mag2     = neg2 ? -d.opdata2_i : d.opdata2_i;
        rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        ge       = rem_sh >= {1'b0, dsr_q};
        rem_fix  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        quo_fix  = qneg_q ? -quo_q : quo_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        rneg_d   = rneg_q;
        qneg_d   = qneg_q;
        dsr_d    = dsr_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        ready_d  = ready_q;
        result_d = result_q;
        case (state_q)
            FREE: if (d.start_i && !d.annul_i) begin
                rneg_d   = neg1;
                qneg_d   = neg1 ^ neg2;
                quo_d    = mag1;
                dsr_d    = mag2;
                rem_d    = '0;
                cnt_d    = '0;
                ready_d  = 1'b0;
                result_d = '0;
                state_d  = (d.opdata2_i == '0) ? BYZERO : ON;
            end
            BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = END;
            end
            ON: if (cnt_q == LAST) begin
                result_d = {rem_fix, quo_fix};
                ready_d  = 1'b1;
                state_d  = END;
            end else begin
                rem_d = ge ? rem_sh - {1'b0, dsr_q} : rem_sh;
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CW'(1);
            end
            END: if (!d.start_i) begin
                state_d  = FREE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
        if (d.annul_i && (state_q == ON || state_q == BYZERO)) begin
            state_d  = FREE;
            ready_d  = 1'b0;
            result_d = '0;
            cnt_d    = '0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rneg_q   <= 1'b0;
            qneg_q   <= 1'b0;
            dsr_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rneg_q   <= rneg_d;
            qneg_q   <= qneg_d;
            dsr_q    <= dsr_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter at WIDTH=32 and WIDTH=8
module tb_div_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) i32 ();
    div_iter_if #(.WIDTH(8))  i8 ();

    div_iter #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .d(i32));
    div_iter #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .d(i8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // truncating division on w-bit operands, remainder carries the dividend's sign, x/0 = 0/0
    function automatic logic [63:0] ref_div(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, m;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (s && sa[w-1]) sa -= m + 1;
        if (s && sb[w-1]) sb -= m + 1;
        if (sb == 0) return '0;
        return (((sa % sb) & m) << w) | ((sa / sb) & m);
    endfunction

    task automatic op32(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [63:0] res, output int lat, output int bsy);
        @(negedge clk);
        i32.signed_div_i = s; i32.opdata1_i = a; i32.opdata2_i = b; i32.start_i = 1'b1;
        @(posedge clk); #1;
        bsy = int'(i32.busy_o);
        lat = 0;
        @(negedge clk);
        i32.opdata1_i = $urandom; i32.opdata2_i = $urandom; i32.signed_div_i = 1'($urandom);
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (i32.ready_o) break;
            bsy += int'(i32.busy_o);
            if (lat > 60) begin
                chk("w32_ready_timeout", 64'(i32.ready_o), 64'd1);
                break;
            end
        end
        res = i32.result_o;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("w32_hold_ready", 64'(i32.ready_o), 64'd1);
            chk("w32_hold_result", i32.result_o, res);
        end
        @(negedge clk) i32.start_i = 1'b0;
        @(posedge clk); #1;
        chk("w32_drop_ready", 64'(i32.ready_o), 64'd0);
        chk("w32_drop_result", i32.result_o, 64'd0);
    endtask

    task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output logic [63:0] res, output int lat, output int bsy);
        @(negedge clk);
        i8.signed_div_i = s; i8.opdata1_i = a; i8.opdata2_i = b; i8.start_i = 1'b1;
        @(posedge clk); #1;
        bsy = int'(i8.busy_o);
        lat = 0;
        @(negedge clk);
        i8.opdata1_i = 8'($urandom); i8.opdata2_i = 8'($urandom); i8.signed_div_i = 1'($urandom);
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (i8.ready_o) break;
            bsy += int'(i8.busy_o);
            if (lat > 30) begin
                chk("w8_ready_timeout", 64'(i8.ready_o), 64'd1);
                break;
            end
        end
        res = 64'(i8.result_o);
        @(negedge clk) i8.start_i = 1'b0;
        @(posedge clk); #1;
        chk("w8_drop_ready", 64'(i8.ready_o), 64'd0);
        chk("w8_drop_result", 64'(i8.result_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        int lat, bsy, seen;
        i32.signed_div_i = 0; i32.opdata1_i = 0; i32.opdata2_i = 0; i32.start_i = 0; i32.annul_i = 0;
        i8.signed_div_i = 0;  i8.opdata1_i = 0;  i8.opdata2_i = 0;  i8.start_i = 0;  i8.annul_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(i32.ready_o), 64'd0);
        chk("rst_result", i32.result_o, 64'd0);
        chk("rst_busy", 64'(i32.busy_o), 64'd0);
        chk("rst_busy8", 64'(i8.busy_o), 64'd0);
        @(negedge clk) rst = 1'b0;

        op32(0, 32'd100, 32'd7, 0, res, lat, bsy);
        chk("u100_7", res, {32'd2, 32'd14});
        chk("u100_7_latency", 64'(lat), 64'd33);
        chk("u100_7_busy_cycles", 64'(bsy), 64'd33);

        op32(1, 32'hFFFFFFF9, 32'd2, 0, res, lat, bsy);
        chk("s_m7_2", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
        op32(1, 32'd7, 32'hFFFFFFFE, 0, res, lat, bsy);
        chk("s_7_m2", res, {32'h00000001, 32'hFFFFFFFD});

        op32(1, 32'd5, 32'd0, 0, res, lat, bsy);
        chk("s_div0", res, 64'd0);
        chk("s_div0_latency", 64'(lat), 64'd1);
        chk("s_div0_busy_cycles", 64'(bsy), 64'd1);
        op32(0, 32'd5, 32'd0, 0, res, lat, bsy);
        chk("u_div0", res, 64'd0);
        chk("u_div0_latency", 64'(lat), 64'd1);

        op32(1, 32'h80000000, 32'hFFFFFFFF, 0, res, lat, bsy);
        chk("s_overflow", res, {32'd0, 32'h80000000});
        op32(0, 32'hFFFFFFFF, 32'd1, 0, res, lat, bsy);
        chk("u_max_1", res, {32'd0, 32'hFFFFFFFF});

        op32(0, 32'd1000, 32'd3, 5, res, lat, bsy);
        chk("hold_1000_3", res, {32'd1, 32'd333});

        @(negedge clk);
        i32.signed_div_i = 0; i32.opdata1_i = 32'd1000; i32.opdata2_i = 32'd3; i32.start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        i32.annul_i = 1'b1; i32.start_i = 1'b0;
        @(posedge clk); #1;
        chk("annul_busy", 64'(i32.busy_o), 64'd0);
        chk("annul_ready", 64'(i32.ready_o), 64'd0);
        chk("annul_result", i32.result_o, 64'd0);
        @(negedge clk) i32.annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= int'(i32.ready_o) | int'(i32.busy_o);
        end
        chk("annul_stays_idle", 64'(seen), 64'd0);
        op32(0, 32'd1000, 32'd3, 0, res, lat, bsy);
        chk("after_annul_1000_3", res, {32'd1, 32'd333});

        @(negedge clk);
        i32.signed_div_i = 0; i32.opdata1_i = 32'd1000; i32.opdata2_i = 32'd3; i32.start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; i32.start_i = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", 64'(i32.ready_o), 64'd0);
        chk("midrst_result", i32.result_o, 64'd0);
        chk("midrst_busy", 64'(i32.busy_o), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle", 64'(i32.busy_o), 64'd0);
        op32(0, 32'd7, 32'd2, 0, res, lat, bsy);
        chk("after_rst_7_2", res, {32'd1, 32'd3});

        fork
            begin
                logic [63:0] r;
                logic [31:0] a, b;
                bit s;
                int l, bs;
                for (int k = 0; k < 1000; k++) begin
                    s = 1'($urandom);
                    a = (k % 16 == 5) ? 32'h80000000 : $urandom;
                    b = (k % 8 == 0) ? 32'd0 : (k % 8 == 1) ? 32'd1 : (k % 8 == 2) ? 32'hFFFFFFFF :
                        (k % 8 == 3) ? 32'($urandom_range(1, 15)) : $urandom;
                    op32(s, a, b, 0, r, l, bs);
                    chk("rand32", r, ref_div(32, s, a, b));
                    chk("rand32_latency", 64'(l), (b == 0) ? 64'd1 : 64'd33);
                end
            end
            begin
                logic [63:0] r;
                logic [7:0] a, b;
                bit s;
                int l, bs;
                for (int k = 0; k < 3000; k++) begin
                    s = 1'($urandom);
                    a = 8'($urandom);
                    b = (k % 8 == 0) ? 8'd0 : (k % 8 == 1) ? 8'hFF : 8'($urandom);
                    op8(s, a, b, r, l, bs);
                    chk("rand8", r, ref_div(8, s, 32'(a), 32'(b)));
                    chk("rand8_latency", 64'(l), (b == 0) ? 64'd1 : 64'd9);
                    chk("rand8_busy_cycles", 64'(bs), (b == 0) ? 64'd1 : 64'd9);
                end
            end
        join

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
